// File: rtl/ram_dp_if.sv
// Bus bundle for ram_dp: write port, read port and status.
// Address width is clamped to one bit so a single-word RAM still has a legal address vector.
interface ram_dp_if #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 8
);
    localparam int AW = (ADDRESS_WIDTH < 1) ? 1 : ADDRESS_WIDTH;

    logic                 we;
    logic [AW-1:0]        wa;
    logic [BUS_WIDTH-1:0] X;
    logic                 re;
    logic [AW-1:0]        ra;
    logic [BUS_WIDTH-1:0] O;
    logic                 ovalid;
    logic                 busy;

    modport master (
        output we, wa, X, re, ra,
        input  O, ovalid, busy
    );

    modport slave (
        input  we, wa, X, re, ra,
        output O, ovalid, busy
    );
endinterface

// File: rtl/ram_dp.sv
// Simple dual-port RAM with registered, write-first read port and a
// post-reset clear sequencer that fills every word with INIT_VALUE.
//
// state | meaning
// CLEAR | sequencer writing INIT_VALUE to mem[cnt]; we/re ignored, busy=1
// READY | normal write/read operation, busy=0
module ram_dp #(
    parameter int                   BUS_WIDTH     = 8,
    parameter int                   ADDRESS_WIDTH = 8,
    parameter logic [BUS_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic    clk,
    input  logic    rst,
    ram_dp_if.slave bus
);
    localparam int            AW    = (ADDRESS_WIDTH < 1) ? 1 : ADDRESS_WIDTH;
    localparam int            DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t               state;
    logic [AW-1:0]        cnt;
    logic [BUS_WIDTH-1:0] o_q;
    logic                 ovalid_q;
    logic [AW-1:0]        wa_m;
    logic [AW-1:0]        ra_m;

    logic [BUS_WIDTH-1:0] mem [0:(1<<AW)-1];

    // Masking folds the spare address bit away when DEPTH is 1.
    assign wa_m = bus.wa & LAST;
    assign ra_m = bus.ra & LAST;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= INIT_VALUE;
            end else if (bus.we) begin
                mem[wa_m] <= bus.X;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            o_q      <= '0;
            ovalid_q <= 1'b0;
        end else if (state == CLEAR) begin
            cnt      <= cnt + 1'b1;
            ovalid_q <= 1'b0;
            if (cnt == LAST) begin
                state <= READY;
            end
        end else begin
            if (bus.re) begin
                o_q      <= (bus.we && (wa_m == ra_m)) ? bus.X : mem[ra_m];
                ovalid_q <= 1'b1;
            end else begin
                ovalid_q <= 1'b0;
            end
        end
    end

    assign bus.O      = o_q;
    assign bus.ovalid = ovalid_q;
    assign bus.busy   = (state == CLEAR);
endmodule
